aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Iterative AES-128 encryption sequencer. It accepts one plaintext block per handshake, applies the initial AddRoundKey, and then drives the external combinational round datapath (SubByte → shiftRow → mixColumns → AddRoundKey) once per cycle for NR rounds. It issues the round index to the key-schedule block, asserts the last-round flag so the datapath bypasses mixColumns, and holds the ciphertext until the downstream stage accepts it. It sits between the block input interface and the round datapath in the encrypt core.

## Interface
- DATA_WIDTH, 128, block and round-key width
- NR, 10, number of cipher rounds (10 for AES-128)
- ROUND_W, 4, width of round index; must satisfy 2^ROUND_W > NR
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ctrl_valid_in  in  1  upstream block valid
- ctrl_ready_out  out  1  controller can accept a block
- ctrl_data_in  in  DATA_WIDTH  plaintext block
- rk_round_out  out  ROUND_W  round index requested from key schedule
- rk_in  in  DATA_WIDTH  round key for rk_round_out, same cycle (combinational lookup)
- round_state_out  out  DATA_WIDTH  current state register, fed to round datapath
- round_last_out  out  1  high during round NR; datapath skips mixColumns
- round_data_in  in  DATA_WIDTH  round datapath result for round_state_out
- ctrl_valid_out  out  1  ciphertext valid
- ctrl_ready_in  in  1  downstream accepts ciphertext
- ctrl_data_out  out  DATA_WIDTH  ciphertext (equals state register)

## Operation
- FSM states: IDLE, ROUND, DONE. Reset → IDLE, state register = 0, round counter = 0.
- IDLE: ctrl_ready_out=1 and rk_round_out=0. When ctrl_valid_in=1: state ← ctrl_data_in ^ rk_in, round ← 1, go to ROUND.
- ROUND: rk_round_out=round, and round_last_out=(round==NR). Each cycle: state ← round_data_in. If round==NR, go to DONE; otherwise round ← round+1.
- DONE: ctrl_valid_out=1 and ctrl_data_out=state, both held stable. When ctrl_ready_in=1: go to IDLE and round ← 0. The next block can be accepted no earlier than the following cycle.
- ctrl_ready_out is 0 in ROUND and DONE. Upstream valid is ignored outside IDLE; the data is not consumed.
- Round counter arithmetic is unsigned ROUND_W bits. It never wraps: 1..NR in ROUND, 0 otherwise.
- round_state_out = state register in all states. round_last_out = 0 outside ROUND.
- Reset mid-operation: the in-flight block is discarded, every output goes to its reset value immediately, and no partial ciphertext is ever presented.

## Timing
- Reset values: ctrl_ready_out=0 while rst_n=0, then 1 (IDLE). ctrl_valid_out=0, rk_round_out=0, round_last_out=0, round_state_out=0, ctrl_data_out=0.
- Accept edge E (valid_in & ready_out): ROUND spans cycles E+1 … E+NR, and ctrl_valid_out rises after edge E+NR.
- Latency is NR+1 cycles from acceptance to first valid_out cycle, i.e. 11 cycles for AES-128.
- Minimum block period is NR+2 cycles when ctrl_ready_in is tied high.
- All outputs are registered-state decodes. There are no combinational paths from ctrl_valid_in or ctrl_ready_in to any output.
- Backpressure: valid_out and data_out are held indefinitely while ctrl_ready_in=0.

## Structure
- Shared package aes_pkg holds:
  - state enum (IDLE/ROUND/DONE)
  - AES_NR_128=10
  - ROUND_W
  - AES_BLOCK_W=128
- One sub-module, aes_round_cnt: round counter with load-1, increment, clear, and an is_last compare against NR.
- Datapath and key schedule are external. The controller contains only the state register and the single XOR for round 0.

## Test plan
- FIPS-197 Appendix B, bench wired to the real round datapath and key schedule. Plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → ctrl_data_out 3925841d02dc09fbdc118597196a0b32, with valid_out rising 11 cycles after accept.
- FIPS-197 C.1: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → 69c4e0d86a7b0430d8cdb78070b4c55a. Check rk_round_out steps 0,1,…,10, and round_last_out is high only in the cycle where rk_round_out=10.
- Backpressure: hold ctrl_ready_in=0 for 20 cycles after valid_out rises → data_out stable, ready_out=0, and a second valid_in is not accepted; release → IDLE next cycle.
- Back-to-back with ctrl_valid_in and ctrl_ready_in tied high, two C.1 blocks → accepts 12 cycles apart and two correct ciphertexts.
- Assert rst_n=0 during round 5 → all outputs go to reset values asynchronously. After release, the C.1 vector completes correctly with no stale output.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and controller FSM encoding for the iterative AES-128 encrypt core.
package aes_pkg;
  localparam int AES_NR_128  = 10;
  localparam int ROUND_W     = 4;
  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;
endpackage

// File: rtl/aes_round_cnt.sv
// Round index counter for the AES sequencer: load to 1, step, clear, and flag round NR.
module aes_round_cnt #(
  parameter int NR      = aes_pkg::AES_NR_128,
  parameter int ROUND_W = aes_pkg::ROUND_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_inc,
  input  logic               i_clr,
  output logic [ROUND_W-1:0] o_round,
  output logic               o_is_last
);
  import aes_pkg::*;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);

  logic [ROUND_W-1:0] r_round;

  // Clear wins so the index is back at 0 the moment a block leaves the round phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_round <= '0;
    end else if (i_clr) begin
      r_round <= '0;
    end else if (i_load) begin
      r_round <= ROUND_W'(1);
    end else if (i_inc) begin
      r_round <= r_round + ROUND_W'(1);
    end
  end

  assign o_round   = r_round;
  assign o_is_last = (r_round == LAST_ROUND);
endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: round-0 key add, then drives the external
// round datapath once per cycle for NR rounds and holds the ciphertext for downstream.
module aes_round_ctrl #(
  parameter int DATA_WIDTH = aes_pkg::AES_BLOCK_W,
  parameter int NR         = aes_pkg::AES_NR_128,
  parameter int ROUND_W    = aes_pkg::ROUND_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctrl_valid_in,
  output logic                  ctrl_ready_out,
  input  logic [DATA_WIDTH-1:0] ctrl_data_in,
  output logic [ROUND_W-1:0]    rk_round_out,
  input  logic [DATA_WIDTH-1:0] rk_in,
  output logic [DATA_WIDTH-1:0] round_state_out,
  output logic                  round_last_out,
  input  logic [DATA_WIDTH-1:0] round_data_in,
  output logic                  ctrl_valid_out,
  input  logic                  ctrl_ready_in,
  output logic [DATA_WIDTH-1:0] ctrl_data_out,
  output logic [1:0]            dbg_state_out
);
  import aes_pkg::*;

  aes_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_en;
  logic                  w_accept;
  logic                  w_in_round;
  logic                  w_is_last;
  logic                  w_done_ack;
  logic [ROUND_W-1:0]    w_round;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid/data are held stable until that edge and ready never depends on valid.
  assign w_in_round = (r_state == ST_ROUND);
  assign w_accept   = r_en && (r_state == ST_IDLE) && ctrl_valid_in;
  assign w_done_ack = (r_state == ST_DONE) && ctrl_ready_in;

  aes_round_cnt #(
    .NR      (NR),
    .ROUND_W (ROUND_W)
  ) u_round_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept),
    .i_inc     (w_in_round && !w_is_last),
    .i_clr     (w_done_ack || (w_in_round && w_is_last)),
    .o_round   (w_round),
    .o_is_last (w_is_last)
  );

  // r_en keeps ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_en    <= 1'b0;
    end else begin
      r_en <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data  <= ctrl_data_in ^ rk_in;
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_data <= round_data_in;
          if (w_is_last) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (ctrl_ready_in) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ctrl_ready_out  = r_en && (r_state == ST_IDLE);
  assign ctrl_valid_out  = (r_state == ST_DONE);
  assign ctrl_data_out   = r_data;
  assign round_state_out = r_data;
  assign rk_round_out    = w_in_round ? w_round : '0;
  assign round_last_out  = w_in_round && w_is_last;
  assign dbg_state_out   = r_state;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: wires a behavioural AES round datapath and key schedule
// around the controller and scores ciphertexts against a full AES-128 model.
`timescale 1ns/1ps
module tb_aes_round_ctrl;
  localparam int NR = 10;
  localparam int RW = 4;

  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef logic [127:0] rk_arr_t [0:NR];

  logic          clk;
  logic          rst_n;
  logic          ctrl_valid_in;
  logic          ctrl_ready_out;
  logic [127:0]  ctrl_data_in;
  logic [RW-1:0] rk_round_out;
  logic [127:0]  rk_in;
  logic [127:0]  round_state_out;
  logic          round_last_out;
  logic [127:0]  round_data_in;
  logic          ctrl_valid_out;
  logic          ctrl_ready_in;
  logic [127:0]  ctrl_data_out;
  logic [1:0]    dbg_state;

  logic [7:0]    sbox_t [0:255];
  rk_arr_t       rk_tab;
  logic [127:0]  cur_key;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [127:0] exp_q[$];
  logic [127:0] out_q[$];
  int           acc_cyc_q[$];
  int           out_cyc_q[$];

  aes_round_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ctrl_valid_in   (ctrl_valid_in),
    .ctrl_ready_out  (ctrl_ready_out),
    .ctrl_data_in    (ctrl_data_in),
    .rk_round_out    (rk_round_out),
    .rk_in           (rk_in),
    .round_state_out (round_state_out),
    .round_last_out  (round_last_out),
    .round_data_in   (round_data_in),
    .ctrl_valid_out  (ctrl_valid_out),
    .ctrl_ready_in   (ctrl_ready_in),
    .ctrl_data_out   (ctrl_data_out),
    .dbg_state_out   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, b);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [0:15];
    logic [7:0]   b [0:15];
    logic [7:0]   c0, c1, c2, c3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
        b[4*c]   = gmul(c0, 8'h02) ^ gmul(c1, 8'h03) ^ c2 ^ c3;
        b[4*c+1] = c0 ^ gmul(c1, 8'h02) ^ gmul(c2, 8'h03) ^ c3;
        b[4*c+2] = c0 ^ c1 ^ gmul(c2, 8'h02) ^ gmul(c3, 8'h03);
        b[4*c+3] = gmul(c0, 8'h03) ^ c1 ^ c2 ^ gmul(c3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  function automatic rk_arr_t key_expand(input logic [127:0] key);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] t;
    logic [7:0]  rc;
    rk_arr_t     rk;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*NR+4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    rk_arr_t      rk;
    logic [127:0] s;
    rk = key_expand(key);
    s  = pt ^ rk[0];
    for (int r = 1; r <= NR; r++) s = aes_round(s, rk[r], r == NR);
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // External datapath and key schedule around the controller.
  assign rk_in         = (int'(rk_round_out) <= NR) ? rk_tab[rk_round_out] : '0;
  assign round_data_in = aes_round(round_state_out, rk_in, round_last_out);

  // ---------------- monitor / scoreboard capture ----------------
  always @(posedge clk) begin
    if (rst_n && ctrl_valid_in && ctrl_ready_out) begin
      acc_cyc_q.push_back(cyc);
      exp_q.push_back(aes_encrypt(ctrl_data_in, cur_key));
    end
    if (rst_n && ctrl_valid_out && ctrl_ready_in) begin
      out_cyc_q.push_back(cyc);
      out_q.push_back(ctrl_data_out);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] key);
    cur_key = key;
    rk_tab  = key_expand(key);
  endtask

  task automatic send_block(input logic [127:0] pt, output bit ok);
    int n0;
    n0 = acc_cyc_q.size();
    ctrl_data_in  = pt;
    ctrl_valid_in = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (acc_cyc_q.size() > n0) ok = 1'b1;
    end
    ctrl_valid_in = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (ctrl_valid_out !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    ok = (ctrl_valid_out === 1'b1);
  endtask

  task automatic take_output(output logic [127:0] got, output logic [127:0] want, output bit ok);
    ctrl_ready_in = 1'b1;
    tick();
    ctrl_ready_in = 1'b0;
    ok = (out_q.size() > 0) && (exp_q.size() > 0);
    got  = '0;
    want = '0;
    if (ok) begin
      got  = out_q.pop_front();
      want = exp_q.pop_front();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; ctrl_valid_in = 1'b0; ctrl_ready_in = 1'b0; ctrl_data_in = '0;
    #2;
    total++; if (ctrl_ready_out !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", ctrl_ready_out); end
    total++; if (ctrl_valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", ctrl_valid_out); end
    total++; if (rk_round_out !== 4'd0) begin bad++; $display("FAIL rst_rk got=%0d want=0", rk_round_out); end
    total++; if (round_last_out !== 1'b0) begin bad++; $display("FAIL rst_last got=%b want=0", round_last_out); end
    total++; if (round_state_out !== 128'h0) begin bad++; $display("FAIL rst_state got=%h want=0", round_state_out); end
    total++; if (ctrl_data_out !== 128'h0) begin bad++; $display("FAIL rst_data got=%h want=0", ctrl_data_out); end
    repeat (3) tick();
    total++; if (ctrl_ready_out !== 1'b0) begin bad++; $display("FAIL rst_hold_ready got=%b want=0", ctrl_ready_out); end
    rst_n = 1'b1;
    tick();
    total++; if (ctrl_ready_out !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", ctrl_ready_out); end
    total++; if (ctrl_valid_out !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%b want=0", ctrl_valid_out); end
  endtask

  task automatic test_fips_b();
    logic [127:0] got, want;
    bit ok;
    int lat;
    load_key(B_KEY);
    send_block(B_PT, ok);
    total++; if (!ok) begin bad++; $display("FAIL b_accept got=timeout want=accept"); end
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL b_valid got=timeout want=valid"); end
    if (acc_cyc_q.size() > 0) begin
      lat = cyc - acc_cyc_q[$];
      total++; if (lat != NR + 1) begin bad++; $display("FAIL b_latency got=%0d want=%0d", lat, NR + 1); end
    end
    take_output(got, want, ok);
    total++; if (!ok) begin bad++; $display("FAIL b_output got=none want=one"); end
    total++; if (got !== B_CT) begin bad++; $display("FAIL b_ct got=%h want=%h", got, B_CT); end
    total++; if (got !== want) begin bad++; $display("FAIL b_model got=%h want=%h", got, want); end
  endtask

  task automatic test_c1_trace();
    logic [127:0] got, want;
    bit ok;
    logic want_last;
    load_key(C_KEY);
    ctrl_data_in  = C_PT;
    ctrl_valid_in = 1'b1;
    total++; if (rk_round_out !== 4'd0) begin bad++; $display("FAIL c1_rk0 got=%0d want=0", rk_round_out); end
    total++; if (ctrl_ready_out !== 1'b1) begin bad++; $display("FAIL c1_ready got=%b want=1", ctrl_ready_out); end
    tick();
    ctrl_valid_in = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      want_last = (k == NR);
      total++; if (int'(rk_round_out) != k) begin bad++; $display("FAIL c1_rk got=%0d want=%0d", rk_round_out, k); end
      total++; if (round_last_out !== want_last) begin bad++; $display("FAIL c1_last round=%0d got=%b want=%b", k, round_last_out, want_last); end
      total++; if (ctrl_valid_out !== 1'b0) begin bad++; $display("FAIL c1_early_valid round=%0d got=%b want=0", k, ctrl_valid_out); end
      tick();
    end
    total++; if (ctrl_valid_out !== 1'b1) begin bad++; $display("FAIL c1_valid got=%b want=1", ctrl_valid_out); end
    total++; if (rk_round_out !== 4'd0) begin bad++; $display("FAIL c1_rk_done got=%0d want=0", rk_round_out); end
    total++; if (round_last_out !== 1'b0) begin bad++; $display("FAIL c1_last_done got=%b want=0", round_last_out); end
    total++; if (ctrl_ready_out !== 1'b0) begin bad++; $display("FAIL c1_ready_done got=%b want=0", ctrl_ready_out); end
    take_output(got, want, ok);
    total++; if (got !== C_CT) begin bad++; $display("FAIL c1_ct got=%h want=%h", got, C_CT); end
    total++; if (got !== want) begin bad++; $display("FAIL c1_model got=%h want=%h", got, want); end
  endtask

  task automatic test_backpressure();
    logic [127:0] got, want;
    bit ok;
    int n0;
    load_key(C_KEY);
    send_block(C_PT, ok);
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_valid got=timeout want=valid"); end
    n0 = acc_cyc_q.size();
    for (int i = 0; i < 20; i++) begin
      ctrl_valid_in = 1'b1;
      ctrl_data_in  = rand128();
      tick();
      total++; if (ctrl_valid_out !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", i, ctrl_valid_out); end
      total++; if (ctrl_ready_out !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b want=0", i, ctrl_ready_out); end
      total++; if (ctrl_data_out !== C_CT) begin bad++; $display("FAIL bp_data cyc=%0d got=%h want=%h", i, ctrl_data_out, C_CT); end
    end
    ctrl_valid_in = 1'b0;
    total++; if (acc_cyc_q.size() != n0) begin bad++; $display("FAIL bp_no_accept got=%0d want=%0d", acc_cyc_q.size(), n0); end
    take_output(got, want, ok);
    total++; if (got !== C_CT) begin bad++; $display("FAIL bp_ct got=%h want=%h", got, C_CT); end
    total++; if (ctrl_ready_out !== 1'b1) begin bad++; $display("FAIL bp_idle_ready got=%b want=1", ctrl_ready_out); end
    total++; if (ctrl_valid_out !== 1'b0) begin bad++; $display("FAIL bp_idle_valid got=%b want=0", ctrl_valid_out); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] got, want;
    int n0, m0;
    load_key(C_KEY);
    n0 = acc_cyc_q.size();
    m0 = out_cyc_q.size();
    ctrl_ready_in = 1'b1;
    ctrl_data_in  = C_PT;
    ctrl_valid_in = 1'b1;
    for (int i = 0; i < 60 && acc_cyc_q.size() < n0 + 2; i++) tick();
    ctrl_valid_in = 1'b0;
    for (int i = 0; i < 40 && out_cyc_q.size() < m0 + 2; i++) tick();
    ctrl_ready_in = 1'b0;
    total++; if (acc_cyc_q.size() != n0 + 2) begin bad++; $display("FAIL b2b_accepts got=%0d want=%0d", acc_cyc_q.size() - n0, 2); end
    total++; if (out_cyc_q.size() != m0 + 2) begin bad++; $display("FAIL b2b_outputs got=%0d want=%0d", out_cyc_q.size() - m0, 2); end
    if (acc_cyc_q.size() >= n0 + 2) begin
      total++; if (acc_cyc_q[n0+1] - acc_cyc_q[n0] != NR + 2) begin bad++; $display("FAIL b2b_period got=%0d want=%0d", acc_cyc_q[n0+1] - acc_cyc_q[n0], NR + 2); end
    end
    if (out_cyc_q.size() > m0 && acc_cyc_q.size() > n0) begin
      total++; if (out_cyc_q[m0] - acc_cyc_q[n0] != NR + 1) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", out_cyc_q[m0] - acc_cyc_q[n0], NR + 1); end
    end
    for (int k = 0; k < 2; k++) begin
      if (out_q.size() > 0 && exp_q.size() > 0) begin
        got  = out_q.pop_front();
        want = exp_q.pop_front();
        total++; if (got !== C_CT) begin bad++; $display("FAIL b2b_ct blk=%0d got=%h want=%h", k, got, C_CT); end
        total++; if (got !== want) begin bad++; $display("FAIL b2b_model blk=%0d got=%h want=%h", k, got, want); end
      end
    end
  endtask

  task automatic test_reset_mid_round();
    logic [127:0] got, want;
    bit ok;
    int m0;
    load_key(C_KEY);
    send_block(C_PT, ok);
    for (int i = 0; i < 20 && rk_round_out !== 4'd5; i++) tick();
    total++; if (rk_round_out !== 4'd5) begin bad++; $display("FAIL mr_round5 got=%0d want=5", rk_round_out); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (ctrl_ready_out !== 1'b0) begin bad++; $display("FAIL mr_ready got=%b want=0", ctrl_ready_out); end
    total++; if (ctrl_valid_out !== 1'b0) begin bad++; $display("FAIL mr_valid got=%b want=0", ctrl_valid_out); end
    total++; if (rk_round_out !== 4'd0) begin bad++; $display("FAIL mr_rk got=%0d want=0", rk_round_out); end
    total++; if (round_last_out !== 1'b0) begin bad++; $display("FAIL mr_last got=%b want=0", round_last_out); end
    total++; if (round_state_out !== 128'h0) begin bad++; $display("FAIL mr_state got=%h want=0", round_state_out); end
    total++; if (ctrl_data_out !== 128'h0) begin bad++; $display("FAIL mr_data got=%h want=0", ctrl_data_out); end
    exp_q.delete();
    m0 = out_q.size();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (ctrl_ready_out !== 1'b1) begin bad++; $display("FAIL mr_post_ready got=%b want=1", ctrl_ready_out); end
    total++; if (ctrl_valid_out !== 1'b0) begin bad++; $display("FAIL mr_post_valid got=%b want=0", ctrl_valid_out); end
    total++; if (out_q.size() != m0) begin bad++; $display("FAIL mr_stale got=%0d want=%0d", out_q.size(), m0); end
    send_block(C_PT, ok);
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL mr_rerun_valid got=timeout want=valid"); end
    take_output(got, want, ok);
    total++; if (got !== C_CT) begin bad++; $display("FAIL mr_ct got=%h want=%h", got, C_CT); end
    total++; if (got !== want) begin bad++; $display("FAIL mr_model got=%h want=%h", got, want); end
  endtask

  task automatic test_random();
    logic [127:0] key, pt, got, want, ref_ct;
    bit ok;
    int hold;
    for (int n = 0; n < 8; n++) begin
      key = rand128();
      pt  = rand128();
      ref_ct = aes_encrypt(pt, key);
      load_key(key);
      repeat ($urandom_range(0, 2)) tick();
      send_block(pt, ok);
      wait_valid(ok);
      total++; if (!ok) begin bad++; $display("FAIL rnd_valid blk=%0d got=timeout want=valid", n); end
      hold = $urandom_range(0, 4);
      repeat (hold) tick();
      total++; if (ctrl_data_out !== ref_ct) begin bad++; $display("FAIL rnd_held blk=%0d got=%h want=%h", n, ctrl_data_out, ref_ct); end
      take_output(got, want, ok);
      total++; if (got !== ref_ct) begin bad++; $display("FAIL rnd_ct blk=%0d got=%h want=%h", n, got, ref_ct); end
      total++; if (want !== ref_ct) begin bad++; $display("FAIL rnd_accepted_data blk=%0d got=%h want=%h", n, want, ref_ct); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ctrl_valid_in = 1'b0;
    ctrl_ready_in = 1'b0;
    ctrl_data_in  = '0;
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
    load_key(C_KEY);
    test_reset();
    test_fips_b();
    test_c1_trace();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_round();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
